// File: rtl/glb_pkg.sv
// Shared widths and FSM encoding for the weight-GLB read scheduler.
package glb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 8;
    localparam int N_PE   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_BURST,
        ST_DONE
    } state_e;

endpackage

// File: rtl/glb_rd_skid.sv
// Two-entry FIFO that absorbs the one-cycle GLB read latency.
module glb_rd_skid #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          valid,
    output logic [1:0]    occ
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wp_q, wp_d;
    logic          rp_q, rp_d;
    logic [1:0]    cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            mem_d[wp_q] = push_data;
            wp_d        = ~wp_q;
        end
        if (pop) begin
            rp_d = ~rp_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rp_q];
    assign valid = (cnt_q != 2'd0);
    assign occ   = cnt_q;

endmodule

// File: rtl/glb_weight_sched.sv
// Round-robin burst scheduler sharing the weight GLB read port among PE scratchpads.
module glb_weight_sched
    import glb_pkg::*;
#(
    parameter int DATA_BITWIDTH = DATA_W,
    parameter int ADDR_BITWIDTH = ADDR_W,
    parameter int NUM_PE        = N_PE,
    parameter int LEN_BITWIDTH  = LEN_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_BITWIDTH-1:0] cfg_base_addr,
    input  logic [LEN_BITWIDTH-1:0]  cfg_burst_len,
    input  logic [LEN_BITWIDTH-1:0]  cfg_num_bursts,
    output logic                     busy,
    output logic                     done,
    input  logic [NUM_PE-1:0]        pe_req,
    output logic [NUM_PE-1:0]        pe_grant,
    output logic                     glb_read_req,
    output logic [ADDR_BITWIDTH-1:0] glb_r_addr,
    input  logic [DATA_BITWIDTH-1:0] glb_r_data,
    output logic [DATA_BITWIDTH-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    state_e                   state_q, state_d;
    logic [LEN_BITWIDTH-1:0]  len_q, len_d;
    logic [LEN_BITWIDTH-1:0]  nb_q, nb_d;
    logic [ADDR_BITWIDTH-1:0] ptr_q, ptr_d;
    logic [LEN_BITWIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_BITWIDTH-1:0]  acc_cnt_q, acc_cnt_d;
    logic [LEN_BITWIDTH-1:0]  burst_cnt_q, burst_cnt_d;
    logic [NUM_PE-1:0]        grant_q, grant_d;
    logic [PW-1:0]            prio_q, prio_d;
    logic                     rd_q, rd_d;

    logic                     pop;
    logic                     read_en;
    logic                     last_acc;
    logic [1:0]               occ;
    logic [2:0]               inflight;
    logic                     found;
    logic [PW-1:0]            win_idx;

    glb_rd_skid #(
        .DW(DATA_BITWIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .push     (rd_q),
        .push_data(glb_r_data),
        .pop      (pop),
        .head     (out_data),
        .valid    (out_valid),
        .occ      (occ)
    );

    // Requesters at or above the priority pointer win first, then wrap to the rest.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (!found && pe_req[i] && (PW'(i) >= prio_q)) begin
                found   = 1'b1;
                win_idx = PW'(i);
            end
        end
        for (int i = 0; i < NUM_PE; i++) begin
            if (!found && pe_req[i]) begin
                found   = 1'b1;
                win_idx = PW'(i);
            end
        end
    end

    assign pop      = out_valid && out_ready;
    assign out_last = out_valid && (state_q == ST_BURST)
                      && (acc_cnt_q == len_q - LEN_BITWIDTH'(1));
    assign last_acc = pop && out_last;
    // Words buffered plus in flight, net of this cycle's pop, must leave room.
    assign inflight = {1'b0, occ} + {2'b0, rd_q} - {2'b0, pop};
    assign read_en  = (state_q == ST_BURST) && (rd_cnt_q < len_q)
                      && (inflight < 3'd2);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        nb_d        = nb_q;
        ptr_d       = ptr_q;
        rd_cnt_d    = rd_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        burst_cnt_d = burst_cnt_q;
        grant_d     = grant_q;
        prio_d      = prio_q;
        rd_d        = read_en;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d       = cfg_burst_len;
                    nb_d        = cfg_num_bursts;
                    ptr_d       = cfg_base_addr;
                    burst_cnt_d = '0;
                    if (cfg_burst_len == '0 || cfg_num_bursts == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ARB;
                    end
                end
            end
            ST_ARB: begin
                if (found) begin
                    grant_d   = NUM_PE'(1) << win_idx;
                    prio_d    = (win_idx == PW'(NUM_PE - 1)) ? '0 : win_idx + PW'(1);
                    rd_cnt_d  = '0;
                    acc_cnt_d = '0;
                    state_d   = ST_BURST;
                end
            end
            ST_BURST: begin
                if (read_en) begin
                    ptr_d    = ptr_q + ADDR_BITWIDTH'(1);
                    rd_cnt_d = rd_cnt_q + LEN_BITWIDTH'(1);
                end
                if (pop) begin
                    acc_cnt_d = acc_cnt_q + LEN_BITWIDTH'(1);
                end
                if (last_acc) begin
                    grant_d     = '0;
                    burst_cnt_d = burst_cnt_q + LEN_BITWIDTH'(1);
                    if (burst_cnt_q + LEN_BITWIDTH'(1) == nb_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ARB;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            nb_q        <= '0;
            ptr_q       <= '0;
            rd_cnt_q    <= '0;
            acc_cnt_q   <= '0;
            burst_cnt_q <= '0;
            grant_q     <= '0;
            prio_q      <= '0;
            rd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            nb_q        <= nb_d;
            ptr_q       <= ptr_d;
            rd_cnt_q    <= rd_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            grant_q     <= grant_d;
            prio_q      <= prio_d;
            rd_q        <= rd_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign pe_grant     = grant_q;
    assign glb_read_req = read_en;
    assign glb_r_addr   = ptr_q;

endmodule

// File: tb/tb_glb_weight_sched.sv
// Scoreboard bench: reference model predicts words, addresses and grants per job.
module tb_glb_weight_sched;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int LW = 8;
    localparam int NP = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [LW-1:0] cfg_burst_len = '0;
    logic [LW-1:0] cfg_num_bursts = '0;
    logic          busy, done;
    logic [NP-1:0] pe_req = '0;
    logic [NP-1:0] pe_grant;
    logic          glb_read_req;
    logic [AW-1:0] glb_r_addr;
    logic [DW-1:0] glb_r_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;

    glb_weight_sched dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_burst_len (cfg_burst_len),
        .cfg_num_bursts(cfg_num_bursts),
        .busy          (busy),
        .done          (done),
        .pe_req        (pe_req),
        .pe_grant      (pe_grant),
        .glb_read_req  (glb_read_req),
        .glb_r_addr    (glb_r_addr),
        .glb_r_data    (glb_r_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        logic [NP-1:0] g;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] mem[1024];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            rr_prio = 0;
    int            ready_mode = 0;

    // GLB: one-cycle read latency, garbage on the bus when not reading
    always @(posedge clk) begin
        if (glb_read_req) glb_r_data <= mem[glb_r_addr];
        else glb_r_data <= DW'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT reads or transfers
    initial begin
        int issued, accepted;
        logic pv, pr;
        logic [DW-1:0] pd;
        exp_t e;
        issued = 0; accepted = 0; pv = 0; pr = 0; pd = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                issued = 0; accepted = 0; pv = 0; pr = 0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", 32'(out_valid), 1);
                    chk("hold_data", 32'(out_data), 32'(pd));
                end
                if (out_valid && out_ready) begin
                    accepted++;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL extra_word: got %0h expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 32'(out_data), 32'(e.d));
                        chk("out_last", 32'(out_last), 32'(e.last));
                        chk("pe_grant", 32'(pe_grant), 32'(e.g));
                    end
                end
                if (glb_read_req) begin
                    issued++;
                    if (addr_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL extra_read: got %0h expected none", glb_r_addr);
                    end else begin
                        chk("rd_addr", 32'(glb_r_addr), 32'(addr_q.pop_front()));
                    end
                    chk("outstanding_le2", 32'(issued - accepted <= 2), 1);
                end
                pv = out_valid; pr = out_ready; pd = out_data;
            end
        end
    end

    task automatic build_model(input logic [AW-1:0] base, input int len, input int nb,
                               input logic [NP-1:0] req);
        int k, w;
        exp_t e;
        k = 0;
        if (len == 0 || nb == 0) return;
        for (int b = 0; b < nb; b++) begin
            w = 0;
            for (int s = 0; s < NP; s++) begin
                int i;
                i = (rr_prio + s) % NP;
                if (req[i]) begin w = i; break; end
            end
            rr_prio = (w + 1) % NP;
            for (int j = 0; j < len; j++) begin
                e.d = mem[AW'(int'(base) + k)];
                e.last = (j == len - 1);
                e.g = NP'(1) << w;
                exp_q.push_back(e);
                addr_q.push_back(AW'(int'(base) + k));
                k++;
            end
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] base, input int len, input int nb);
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_base_addr = base;
        cfg_burst_len = LW'(len);
        cfg_num_bursts = LW'(nb);
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_base_addr = AW'($urandom);
        cfg_burst_len = LW'($urandom);
        cfg_num_bursts = LW'($urandom);
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int len, input int nb,
                           input logic [NP-1:0] req, input int rm, input bit poke);
        bit got;
        int cyc;
        bit zero;
        zero = (len == 0 || nb == 0);
        ready_mode = rm;
        pe_req = req;
        build_model(base, len, nb, req);
        pulse_start(base, len, nb);
        got = 0;
        for (cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 1 && !zero) chk("busy_after_start", 32'(busy), 1);
            if (poke && cyc == 3) begin
                start = 1'b1;
                cfg_base_addr = AW'($urandom);
                cfg_burst_len = 8'd3;
                cfg_num_bursts = 8'd1;
            end
            if (poke && cyc == 4) start = 1'b0;
            if (done) begin got = 1; break; end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 3000 cycles");
            exp_q.delete();
            addr_q.delete();
        end else if (zero) begin
            chk("done_latency", 32'(cyc), 1);
        end
        @(negedge clk);
        chk("done_pulse_1cyc", 32'(done), 0);
        chk("busy_cleared", 32'(busy), 0);
        chk("words_left", 32'(exp_q.size()), 0);
        chk("reads_left", 32'(addr_q.size()), 0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_grant"}, 32'(pe_grant), 0);
        chk({tag, "_rdreq"}, 32'(glb_read_req), 0);
        chk({tag, "_addr"}, 32'(glb_r_addr), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_last"}, 32'(out_last), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        rr_prio = 0;

        run_job(AW'($urandom), 2, 4, 3'b111, 0, 0);
        run_job(10'h010, 4, 1, 3'b001, 0, 0);
        run_job(AW'($urandom), 8, 1, NP'($urandom_range(1, 7)), 1, 0);
        run_job(10'h3FE, 4, 1, 3'b010, 0, 0);
        run_job(AW'($urandom), 0, 3, 3'b111, 0, 0);
        run_job(AW'($urandom), 5, 0, 3'b111, 0, 0);
        run_job(AW'($urandom), 8, 2, 3'b101, 2, 1);

        ready_mode = 0;
        pe_req = 3'b110;
        build_model(10'h123, 8, 2, 3'b110);
        pulse_start(10'h123, 8, 2);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outs("midreset");
        exp_q.delete();
        addr_q.delete();
        rr_prio = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        run_job(AW'($urandom), 3, 3, 3'b111, 0, 0);

        repeat (15) begin
            run_job(AW'($urandom), $urandom_range(0, 6), $urandom_range(0, 4),
                    NP'($urandom_range(1, 7)), $urandom_range(0, 2), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
